// File: rtl/fifo_wc_pkg.sv
// Shared helpers for the write-wide / read-narrow FIFO.
// The sizing values depend on module parameters, so they are provided as
// constant functions and each module turns them into local parameters:
//   fifo_wc_depth     : DEPTH = 2**ADDR_WIDTH narrow entries
//   fifo_wc_row_bits  : ROW_BITS = $clog2(RATIO), the low index bits inside one wide row
//   fifo_wc_params_ok : RATIO is a power of two >= 2, and the storage holds at least two rows
package fifo_wc_pkg;

   function automatic int fifo_wc_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

   function automatic int fifo_wc_row_bits(input int ratio);
      return $clog2(ratio);
   endfunction

   function automatic bit fifo_wc_params_ok(input int ratio, input int addr_width);
      return (ratio >= 2) && ((ratio & (ratio - 1)) == 0) &&
             ((1 << addr_width) >= 2 * ratio);
   endfunction

endpackage

// File: rtl/fifo_wc_controller.sv
// Pointer, fill level and flag logic for the width-converting FIFO.
// The write pointer steps by RATIO, so it always lands on the start of a
// row. The read pointer steps by 1. Both pointers carry one extra wrap bit,
// which lets the fill level be taken as a plain modular difference.
// Ports:
//   clk_i, reset_ni      clock and asynchronous active-low reset
//   write_i, read_i      push and pop requests
//   wr_en_o              write accepted this cycle (storage update strobe)
//   wr_row_o             row index written by an accepted write
//   rd_idx_o             storage index of the head entry
//   empty_o, full_o      registered status flags
//   count_o              number of stored narrow entries
//   overflow_o           one-cycle pulse after a rejected write
//   underflow_o          one-cycle pulse after a rejected read
module fifo_wc_controller
   import fifo_wc_pkg::*;
#(
   parameter int RATIO      = 4,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                                            clk_i,
   input  logic                                            reset_ni,
   input  logic                                            write_i,
   input  logic                                            read_i,
   output logic                                            wr_en_o,
   output logic [ADDR_WIDTH-fifo_wc_row_bits(RATIO)-1:0]   wr_row_o,
   output logic [ADDR_WIDTH-1:0]                           rd_idx_o,
   output logic                                            empty_o,
   output logic                                            full_o,
   output logic [ADDR_WIDTH:0]                             count_o,
   output logic                                            overflow_o,
   output logic                                            underflow_o
);

   localparam int DEPTH    = fifo_wc_depth(ADDR_WIDTH);
   localparam int ROW_BITS = fifo_wc_row_bits(RATIO);
   localparam int PTR_W    = ADDR_WIDTH + 1;

   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             wr_acc;
   logic             rd_acc;
   logic [PTR_W-1:0] count_d;
   logic [PTR_W-1:0] free_d;

   // Acceptance uses only the registered flags: a same-cycle read does not
   // make room for a write, and a same-cycle write does not make data readable.
   assign wr_acc = write_i & ~full_q;
   assign rd_acc = read_i & ~empty_q;

   always_comb begin
      wptr_d      = wptr_q + (wr_acc ? PTR_W'(RATIO) : '0);
      rptr_d      = rptr_q + (rd_acc ? PTR_W'(1) : '0);
      count_d     = wptr_d - rptr_d;
      free_d      = PTR_W'(DEPTH) - count_d;
      empty_d     = (count_d == '0);
      full_d      = (free_d < PTR_W'(RATIO));
      overflow_d  = write_i & full_q;
      underflow_d = read_i & empty_q;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         empty_q     <= empty_d;
         full_q      <= full_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign wr_en_o     = wr_acc;
   assign wr_row_o    = wptr_q[ADDR_WIDTH-1:ROW_BITS];
   assign rd_idx_o    = rptr_q[ADDR_WIDTH-1:0];
   assign count_o     = wptr_q - rptr_q;
   assign empty_o     = empty_q;
   assign full_o      = full_q;
   assign overflow_o  = overflow_q;
   assign underflow_o = underflow_q;

endmodule

// File: rtl/fifo_width_conversion_param.sv
// Write-wide / read-narrow FIFO. Each accepted write stores one
// RATIO*DATA_WIDTH word as RATIO narrow entries in one aligned row, with the
// lowest slice first. Each accepted read pops one DATA_WIDTH entry.
// read_data_o is first-word-fall-through.
// Ports:
//   clk_i, reset_ni      clock and asynchronous active-low reset
//   write_i/write_data_i wide push request and data
//   read_i               narrow pop request
//   read_data_o          head entry (valid while empty_o = 0)
//   empty_o, full_o      status; full_o means fewer than RATIO free entries
//   count_o              stored narrow entries, 0..2**ADDR_WIDTH
//   overflow_o           one-cycle pulse after a rejected write
//   underflow_o          one-cycle pulse after a rejected read
module fifo_width_conversion_param
   import fifo_wc_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int RATIO      = 4,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                        clk_i,
   input  logic                        reset_ni,
   input  logic                        write_i,
   input  logic [RATIO*DATA_WIDTH-1:0] write_data_i,
   input  logic                        read_i,
   output logic [DATA_WIDTH-1:0]       read_data_o,
   output logic                        empty_o,
   output logic                        full_o,
   output logic [ADDR_WIDTH:0]         count_o,
   output logic                        overflow_o,
   output logic                        underflow_o
);

   localparam int DEPTH    = fifo_wc_depth(ADDR_WIDTH);
   localparam int ROW_BITS = fifo_wc_row_bits(RATIO);
   localparam int ROW_W    = ADDR_WIDTH - ROW_BITS;

   if (!fifo_wc_params_ok(RATIO, ADDR_WIDTH)) begin : g_param_check
      $error("fifo_width_conversion_param: RATIO must be a power of two >= 2 and 2**ADDR_WIDTH >= 2*RATIO");
   end

   logic                  wr_en;
   logic [ROW_W-1:0]      wr_row;
   logic [ADDR_WIDTH-1:0] rd_idx;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];

   fifo_wc_controller #(
      .RATIO      (RATIO),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ctrl (
      .clk_i       (clk_i),
      .reset_ni    (reset_ni),
      .write_i     (write_i),
      .read_i      (read_i),
      .wr_en_o     (wr_en),
      .wr_row_o    (wr_row),
      .rd_idx_o    (rd_idx),
      .empty_o     (empty_o),
      .full_o      (full_o),
      .count_o     (count_o),
      .overflow_o  (overflow_o),
      .underflow_o (underflow_o)
   );

   // A wide write fills the whole row; slice k lands at row*RATIO + k.
   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         for (int k = 0; k < RATIO; k++) begin
            mem_d[{wr_row, ROW_BITS'(k)}] = write_data_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Storage contents are deliberately not reset; the pointers gate validity.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

   assign read_data_o = mem_q[rd_idx];

endmodule

// File: doc/fifo_width_conversion_param.md
Name: fifo_width_conversion_param

Overview:
- Parametrised write-wide / read-narrow FIFO.
- Each accepted write stores one word of RATIO*DATA_WIDTH bits as RATIO consecutive narrow entries. The lowest slice is stored first.
- Each accepted read pops one DATA_WIDTH entry.
- Sits between a wide producer (e.g. a 32-bit packer) and a byte-serial consumer such as a UART TX. It generalises the fixed 2:1 controller to any power-of-two ratio, with integrated storage, fill level and error flags.

Parameters:
- DATA_WIDTH, 8, width of one read-side (narrow) word in bits.
- RATIO, 4, narrow words per write word. Power of two, >= 2.
- ADDR_WIDTH, 4, depth = 2**ADDR_WIDTH narrow entries. Elaboration error unless 2**ADDR_WIDTH >= 2*RATIO.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_ni  input  1  asynchronous, active-low reset.
- write_i  input  1  write request.
- write_data_i  input  RATIO*DATA_WIDTH  wide write word; bits [DATA_WIDTH-1:0] are read out first.
- read_i  input  1  read request (pop).
- read_data_o  output  DATA_WIDTH  entry at the read pointer. Combinational from storage, first-word-fall-through. Valid while empty_o=0.
- empty_o  output  1  no entries stored.
- full_o  output  1  fewer than RATIO free entries (cannot accept a write).
- count_o  output  ADDR_WIDTH+1  number of stored narrow entries, 0 to 2**ADDR_WIDTH.
- overflow_o  output  1  one-cycle pulse: write requested while full.
- underflow_o  output  1  one-cycle pulse: read requested while empty.

Behaviour:
- Reset (reset_ni=0, asynchronous): read/write pointers=0, count_o=0, empty_o=1, full_o=0, overflow_o=0, underflow_o=0. Storage contents are not reset. read_data_o is don't-care while empty. Asserting reset mid-operation discards all contents immediately, without waiting for a clock edge.
- Pointers are ADDR_WIDTH+1 bits with a wrap bit.
  - Write pointer advances by RATIO, so it is always RATIO-aligned: a wide write fills exactly one aligned row, never split across the wrap.
  - Read pointer advances by 1.
  - count = wptr - rptr, modulo 2**(ADDR_WIDTH+1).
- Write acceptance: write_i=1 and full_o=0, evaluated on the registered state at the edge. A simultaneous read does not free space for the same cycle's write.
- Read acceptance: read_i=1 and empty_o=0, evaluated on the registered state. A simultaneous write does not make data readable in the same cycle.
- Per edge (w = write accepted, r = read accepted):
  - count_next = count + (w ? RATIO : 0) - (r ? 1 : 0).
  - empty_next = (count_next == 0).
  - full_next = (2**ADDR_WIDTH - count_next < RATIO).
- Flags are registered: they change one cycle after the causing request and match count_o exactly.
- Write latency: written data is visible on read_data_o the cycle after the write edge, if it is at the head.
- Rejected requests:
  - No pointer, count or storage change.
  - overflow_o / underflow_o is high for the cycle after the rejected request edge, then clears unless repeated.
  - Errors are independent: a rejected write with an accepted read still performs the read.
- Both requests rejected in the same cycle: both error flags pulse.
- Wrap-around is modulo 2**ADDR_WIDTH on storage indices. Ordering is preserved across any number of wraps.

Decomposition:
- Package fifo_wc_pkg holds:
  - the localparam helpers DEPTH = 2**ADDR_WIDTH and ROW_BITS = $clog2(RATIO);
  - the ratio-legality check function.
- Sub-module fifo_wc_controller holds the pointers, count, flags and error pulses. It outputs the write row index and the read index.
- Top level: fifo_wc_controller plus storage.
  - Storage is a register array of DEPTH entries.
  - A wide write sets RATIO entries at the write row.
  - A narrow read mux selects the entry at the read index.

Test Plan (DATA_WIDTH=8, RATIO=4, ADDR_WIDTH=4; 16 entries):
- Reset: hold reset_ni=0 mid-stream, then release -> empty_o=1, full_o=0, count_o=0, no error pulses. Reset asserted between edges clears flags without a clock edge.
- Order: write 0xDDCCBBAA, then 4 reads -> read_data_o = 0xAA, 0xBB, 0xCC, 0xDD; count_o = 4, 3, 2, 1, 0; empty_o=1 after the 4th read.
- Full/overflow: 4 writes 0x03020100..0x0F0E0D0C -> count_o=16, full_o=1. 5th write 0xFFFFFFFF -> overflow_o pulses one cycle; 16 reads return 0x00..0x0F exactly.
- Near-full: at count=13, one read -> count=12, full_o=0. Write and read together at count=12 -> count_o=15, full_o=1, no overflow.
- Same-cycle rule at count=13 (full): write+read together -> read accepted, write rejected, overflow_o=1, count_o=12.
- Underflow/wrap: read on empty -> underflow_o pulses, count_o stays 0. Then 40 random interleaved write/read cycles cross the wrap ≥2 times -> scoreboard matches byte order, and count_o/flags match the model every cycle.
